// File: rtl/phi_position_tracker.sv
`timescale 1ns/1ps
// phi_position_tracker: time-multiplexed, hysteresis-filtered phi^n position
// classifier. Scans one channel per enabled cycle and emits class-change events.
// Ports: clk/rst (async, active-high), clk_en, sample_valid + n_packed (snapshot),
//   busy/scan_done/overrun status, class/dwell/stability packed per-channel state,
//   evt_valid/evt_ready/evt_chan/evt_old/evt_new handshaked event channel.
// Option: define PPT_STABILITY_EN to build the per-channel stability registers.
module phi_position_tracker #(
    parameter int WIDTH         = 18,
    parameter int FRAC          = 14,
    parameter int NUM_OSC       = 21,
    parameter int CONFIRM       = 3,
    parameter int DWELL_W       = 8,
    parameter int N_DANGER_LOW  = 22118,
    parameter int N_DANGER_HIGH = 25395
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic                         sample_valid,
    input  logic [NUM_OSC*WIDTH-1:0]     n_packed,
    output logic                         busy,
    output logic                         scan_done,
    output logic                         overrun,
    output logic [NUM_OSC*2-1:0]         class_packed,
    output logic [NUM_OSC*DWELL_W-1:0]   dwell_packed,
    output logic [NUM_OSC*WIDTH-1:0]     stability_packed,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [$clog2(NUM_OSC)-1:0]   evt_chan,
    output logic [1:0]                   evt_old,
    output logic [1:0]                   evt_new
);

    localparam int IDXW = $clog2(NUM_OSC);
    localparam logic [1:0] C_INT  = 2'b00;
    localparam logic [1:0] C_HALF = 2'b01;
    localparam logic [1:0] C_QTR  = 2'b10;
    localparam logic [1:0] C_CAT  = 2'b11;
    localparam logic [3:0] CF     = 4'(CONFIRM);
    localparam logic [DWELL_W-1:0] DMAX = '1;
    localparam logic signed [WIDTH-1:0] D_LO = WIDTH'(N_DANGER_LOW);
    localparam logic signed [WIDTH-1:0] D_HI = WIDTH'(N_DANGER_HIGH);
    localparam logic [FRAC:0] RND = (FRAC+1)'(1 << (FRAC-3));

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EVT, S_DONE} state_t;

    state_t state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [NUM_OSC-1:0][WIDTH-1:0]   snap_q;
    logic [NUM_OSC-1:0][1:0]         cls_q;
    logic [NUM_OSC-1:0][1:0]         cand_q;
    logic [NUM_OSC-1:0][3:0]         cnt_q;
    logic [NUM_OSC-1:0][DWELL_W-1:0] dwell_q;
    logic [IDXW-1:0] evt_chan_q;
    logic [1:0]      evt_old_q, evt_new_q;
    logic            evt_taken_q;
    logic            overrun_q;

    logic signed [WIDTH-1:0] n_cur;
    logic [FRAC-1:0] frac;
    logic [FRAC:0]   qsum;
    logic [2:0]      q;
    logic            danger;
    logic [1:0]      raw;
    logic [3:0]      cnt_nx;
    logic            commit;
    logic [DWELL_W-1:0] dwell_nx;
    logic            scan_fire, last, evt_xfer, evt_go;

    assign n_cur  = snap_q[idx_q];
    assign frac   = n_cur[FRAC-1:0];
    assign qsum   = {1'b0, frac} + RND;
    assign q      = 3'(qsum >> (FRAC-2));
    assign danger = (n_cur >= D_LO) && (n_cur <= D_HI);

    always_comb begin
        raw = C_INT;
        unique case (1'b1)
            danger:                                 raw = C_CAT;
            (!danger && q == 3'd2):                 raw = C_HALF;
            (!danger && (q == 3'd1 || q == 3'd3)):  raw = C_QTR;
            default:                                raw = C_INT;
        endcase
    end

    // Candidate count saturates at CONFIRM so a held class never re-commits.
    always_comb begin
        if (raw == cand_q[idx_q])
            cnt_nx = (cnt_q[idx_q] >= CF) ? CF : cnt_q[idx_q] + 4'd1;
        else
            cnt_nx = 4'd1;
        commit = (cnt_nx == CF) && (raw != cls_q[idx_q]);
        if (commit)
            dwell_nx = '0;
        else if (dwell_q[idx_q] == DMAX)
            dwell_nx = DMAX;
        else
            dwell_nx = dwell_q[idx_q] + DWELL_W'(1);
    end

    assign scan_fire = (state_q == S_SCAN) && clk_en;
    assign last      = (idx_q == IDXW'(NUM_OSC-1));
    assign evt_valid = (state_q == S_EVT) && !evt_taken_q;
    assign evt_xfer  = evt_valid && evt_ready;
    // A transfer taken while clk_en is low is remembered until the advance.
    assign evt_go    = (state_q == S_EVT) && clk_en && (evt_taken_q || evt_ready);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: if (clk_en && sample_valid) begin
                state_d = S_SCAN;
                idx_d   = '0;
            end
            S_SCAN: if (clk_en) begin
                if (commit)    state_d = S_EVT;
                else if (last) state_d = S_DONE;
                else           idx_d   = idx_q + IDXW'(1);
            end
            S_EVT: if (evt_go) begin
                if (last) state_d = S_DONE;
                else begin
                    state_d = S_SCAN;
                    idx_d   = idx_q + IDXW'(1);
                end
            end
            S_DONE: if (clk_en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            snap_q      <= '0;
            cls_q       <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            dwell_q     <= '0;
            evt_chan_q  <= '0;
            evt_old_q   <= '0;
            evt_new_q   <= '0;
            evt_taken_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == S_IDLE && clk_en && sample_valid)
                snap_q <= n_packed;
            if (state_q != S_IDLE && clk_en && sample_valid)
                overrun_q <= 1'b1;
            if (scan_fire) begin
                cand_q[idx_q]  <= raw;
                cnt_q[idx_q]   <= cnt_nx;
                dwell_q[idx_q] <= dwell_nx;
                if (commit) begin
                    cls_q[idx_q] <= raw;
                    evt_chan_q   <= idx_q;
                    evt_old_q    <= cls_q[idx_q];
                    evt_new_q    <= raw;
                end
            end
            if (evt_go)
                evt_taken_q <= 1'b0;
            else if (evt_xfer)
                evt_taken_q <= 1'b1;
        end
    end

`ifdef PPT_STABILITY_EN
    localparam int HALF_PT = 1 << (FRAC-1);
    localparam int QTR_PT  = 1 << (FRAC-2);

    logic [NUM_OSC-1:0][WIDTH-1:0] stab_q;
    logic [WIDTH-1:0] stab_d;
    int fr_i, dist;

    always_comb begin
        fr_i   = int'(frac);
        dist   = 0;
        stab_d = '0;
        unique case (raw)
            C_HALF: begin
                dist = fr_i - HALF_PT;
                if (dist < 0) dist = -dist;
                stab_d = WIDTH'((1 << FRAC) - 4*dist);
            end
            C_QTR: begin
                dist = fr_i - ((q == 3'd1) ? QTR_PT : 3*QTR_PT);
                if (dist < 0) dist = -dist;
                stab_d = WIDTH'((1 << (FRAC-1)) - 2*dist);
            end
            C_CAT:   stab_d = WIDTH'(QTR_PT);
            default: stab_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stab_q <= '0;
        else if (scan_fire)
            stab_q[idx_q] <= stab_d;
    end

    assign stability_packed = stab_q;
`else
    assign stability_packed = '0;
`endif

    assign busy         = (state_q == S_SCAN) || (state_q == S_EVT);
    assign scan_done    = (state_q == S_DONE);
    assign overrun      = overrun_q;
    assign class_packed = cls_q;
    assign dwell_packed = dwell_q;
    assign evt_chan     = evt_chan_q;
    assign evt_old      = evt_old_q;
    assign evt_new      = evt_new_q;

endmodule

// File: tb/tb_phi_position_tracker.sv
`timescale 1ns/1ps
// Bench for phi_position_tracker: table of per-channel classification vectors,
// event scoreboard queue, and hand sequences for hysteresis/stall/overrun/reset.
module tb_phi_position_tracker;

    localparam int WIDTH   = 18;
    localparam int FRAC    = 14;
    localparam int NUM_OSC = 21;
    localparam int DWELL_W = 8;
    localparam int IDXW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b1;
    logic sample_valid = 1'b0;
    logic evt_ready = 1'b1;
    logic [NUM_OSC*WIDTH-1:0]   n_packed = '0;
    logic                       busy, scan_done, overrun, evt_valid;
    logic [NUM_OSC*2-1:0]       class_packed;
    logic [NUM_OSC*DWELL_W-1:0] dwell_packed;
    logic [NUM_OSC*WIDTH-1:0]   stability_packed;
    logic [IDXW-1:0]            evt_chan;
    logic [1:0]                 evt_old, evt_new;

    phi_position_tracker dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .sample_valid(sample_valid),
        .n_packed(n_packed), .busy(busy), .scan_done(scan_done),
        .overrun(overrun), .class_packed(class_packed),
        .dwell_packed(dwell_packed), .stability_packed(stability_packed),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_chan(evt_chan),
        .evt_old(evt_old), .evt_new(evt_new)
    );

    always #5 clk = ~clk;

    typedef struct { int n; logic [1:0] cls; } vec_t;
    typedef struct { int chan; logic [1:0] oldc; logic [1:0] newc; } evt_t;

    vec_t tbl [NUM_OSC];
    evt_t evq [$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] stab_exp(input int n, input logic [1:0] c);
`ifdef PPT_STABILITY_EN
        int fr, q, d;
        fr = n & 16383;
        q  = (fr + 2048) >> 12;
        case (c)
            2'b01: begin
                d = fr - 8192; if (d < 0) d = -d;
                return WIDTH'(16384 - 4*d);
            end
            2'b10: begin
                d = fr - ((q == 1) ? 4096 : 12288); if (d < 0) d = -d;
                return WIDTH'(8192 - 2*d);
            end
            2'b11:   return WIDTH'(4096);
            default: return '0;
        endcase
`else
        return '0;
`endif
    endfunction

    // Scoreboard: every accepted event is matched against the queue head.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (evq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL evt_unexpected: chan=%0d old=%0d new=%0d",
                         evt_chan, evt_old, evt_new);
            end else begin
                evt_t e;
                e = evq.pop_front();
                check("evt_chan", 64'(evt_chan), 64'(e.chan));
                check("evt_old", 64'(evt_old), 64'(e.oldc));
                check("evt_new", 64'(evt_new), 64'(e.newc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        clk_en = 1'b1;
        sample_valid = 1'b0;
        evt_ready = 1'b1;
        n_packed = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic start_scan(input logic [NUM_OSC-1:0][WIDTH-1:0] np);
        @(posedge clk);
        #1;
        n_packed = np;
        sample_valid = 1'b1;
        @(posedge clk);
        #1 sample_valid = 1'b0;
    endtask

    task automatic wait_done(output int bc, output bit seen);
        bc = 0;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (scan_done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bc++;
        end
    endtask

    task automatic scan(input logic [NUM_OSC-1:0][WIDTH-1:0] np, output int bc);
        bit s;
        start_scan(np);
        wait_done(bc, s);
        check("scan_done_seen", 64'(s), 64'd1);
    endtask

    task automatic wait_evt(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (evt_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    logic [NUM_OSC-1:0][WIDTH-1:0] np;
    int bc;
    int nev;
    bit seen;
    bit ok;
    logic [IDXW-1:0] sv_chan;
    logic [1:0] sv_old, sv_new;

    initial begin
        tbl[0]  = '{0,      2'b00};
        tbl[1]  = '{8192,   2'b01};
        tbl[2]  = '{4096,   2'b10};
        tbl[3]  = '{12288,  2'b10};
        tbl[4]  = '{2047,   2'b00};
        tbl[5]  = '{2048,   2'b10};
        tbl[6]  = '{6143,   2'b10};
        tbl[7]  = '{6144,   2'b01};
        tbl[8]  = '{10239,  2'b01};
        tbl[9]  = '{10240,  2'b10};
        tbl[10] = '{14335,  2'b10};
        tbl[11] = '{14336,  2'b00};
        tbl[12] = '{-8192,  2'b01};
        tbl[13] = '{-4096,  2'b10};
        tbl[14] = '{-1,     2'b00};
        tbl[15] = '{22118,  2'b11};
        tbl[16] = '{22117,  2'b10};
        tbl[17] = '{25395,  2'b11};
        tbl[18] = '{25396,  2'b01};
        tbl[19] = '{23593,  2'b11};
        tbl[20] = '{36864,  2'b10};

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_scan_done", 64'(scan_done), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_evt_valid", 64'(evt_valid), 64'd0);
        for (int g = 0; g < NUM_OSC; g++) begin
            check("rst_class", 64'(class_packed[g*2 +: 2]), 64'd0);
            check("rst_dwell", 64'(dwell_packed[g*DWELL_W +: DWELL_W]), 64'd0);
            check("rst_stab", 64'(stability_packed[g*WIDTH +: WIDTH]), 64'd0);
        end

        // All-zero snapshot: plain scan latency, dwell 1 everywhere
        np = '0;
        scan(np, bc);
        check("zero_busy_cycles", 64'(bc), 64'd21);
        for (int g = 0; g < NUM_OSC; g++) begin
            check("zero_class", 64'(class_packed[g*2 +: 2]), 64'd0);
            check("zero_dwell", 64'(dwell_packed[g*DWELL_W +: DWELL_W]), 64'd1);
        end

        // Table: one classification vector per channel, three scans
        do_reset();
        for (int g = 0; g < NUM_OSC; g++) np[g] = WIDTH'(tbl[g].n);
        scan(np, bc);
        check("tbl_scan1_cycles", 64'(bc), 64'd21);
        scan(np, bc);
        check("tbl_scan2_cycles", 64'(bc), 64'd21);
        nev = 0;
        for (int g = 0; g < NUM_OSC; g++) begin
            if (tbl[g].cls != 2'b00) begin
                evq.push_back('{g, 2'b00, tbl[g].cls});
                nev++;
            end
        end
        scan(np, bc);
        check("tbl_scan3_cycles", 64'(bc), 64'(21 + nev));
        for (int g = 0; g < NUM_OSC; g++) begin
            check("tbl_class", 64'(class_packed[g*2 +: 2]), 64'(tbl[g].cls));
            check("tbl_dwell", 64'(dwell_packed[g*DWELL_W +: DWELL_W]),
                  (tbl[g].cls == 2'b00) ? 64'd3 : 64'd0);
            check("tbl_stab", 64'(stability_packed[g*WIDTH +: WIDTH]),
                  64'(stab_exp(tbl[g].n, tbl[g].cls)));
        end
        check("tbl_evq_empty", 64'(evq.size()), 64'd0);

        // Hysteresis: ch1 alternates, ch3 goes CAT then QUARTER
        do_reset();
        for (int s = 1; s <= 10; s++) begin
            np = '0;
            np[1] = (s % 2 == 1) ? WIDTH'(8192) : WIDTH'(0);
            np[3] = (s <= 3) ? WIDTH'(23593) : WIDTH'(36864);
            if (s == 3) evq.push_back('{3, 2'b00, 2'b11});
            if (s == 6) evq.push_back('{3, 2'b11, 2'b10});
            scan(np, bc);
            if (s == 3) check("hys_ch3_cat", 64'(class_packed[6 +: 2]), 64'd3);
            if (s == 6) check("hys_ch3_qtr", 64'(class_packed[6 +: 2]), 64'd2);
        end
        check("hys_ch1_class", 64'(class_packed[2 +: 2]), 64'd0);
        check("hys_ch1_dwell", 64'(dwell_packed[DWELL_W +: DWELL_W]), 64'd10);
        check("hys_ch3_dwell", 64'(dwell_packed[3*DWELL_W +: DWELL_W]), 64'd4);
        check("hys_evq_empty", 64'(evq.size()), 64'd0);

        // Back-pressure stall, then a transfer taken while clk_en is low
        do_reset();
        np = '0;
        np[0] = WIDTH'(8192);
        scan(np, bc);
        scan(np, bc);
        evt_ready = 1'b0;
        evq.push_back('{0, 2'b00, 2'b01});
        start_scan(np);
        wait_evt(seen);
        check("stall_evt_valid", 64'(seen), 64'd1);
        sv_chan = evt_chan;
        sv_old = evt_old;
        sv_new = evt_new;
        check("stall_chan", 64'(sv_chan), 64'd0);
        check("stall_ch0_class", 64'(class_packed[1:0]), 64'd1);
        check("stall_ch0_dwell", 64'(dwell_packed[DWELL_W-1:0]), 64'd0);
        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!evt_valid || !busy || scan_done || evt_chan != sv_chan ||
                evt_old != sv_old || evt_new != sv_new)
                ok = 1'b0;
        end
        check("stall_held_stable", 64'(ok), 64'd1);
        check("stall_ch1_dwell", 64'(dwell_packed[DWELL_W +: DWELL_W]), 64'd2);
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        evt_ready = 1'b1;
        @(posedge clk);
        #1 evt_ready = 1'b0;
        @(negedge clk);
        check("gated_evt_dropped", 64'(evt_valid), 64'd0);
        check("gated_busy", 64'(busy), 64'd1);
        repeat (5) @(negedge clk);
        check("gated_still_busy", 64'(busy), 64'd1);
        check("gated_ch1_dwell", 64'(dwell_packed[DWELL_W +: DWELL_W]), 64'd2);
        check("gated_evq_empty", 64'(evq.size()), 64'd0);
        @(posedge clk);
        #1 clk_en = 1'b1;
        wait_done(bc, seen);
        check("gated_scan_done", 64'(seen), 64'd1);
        check("gated_ch1_dwell_end", 64'(dwell_packed[DWELL_W +: DWELL_W]), 64'd3);

        // Overrun and ignored requests
        do_reset();
        np = '0;
        np[0] = WIDTH'(8192);
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        sample_valid = 1'b1;
        n_packed = np;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        clk_en = 1'b1;
        @(negedge clk);
        check("gated_req_no_busy", 64'(busy), 64'd0);
        check("gated_req_no_ovr", 64'(overrun), 64'd0);
        start_scan(np);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        clk_en = 1'b1;
        @(negedge clk);
        check("busy_gated_no_ovr", 64'(overrun), 64'd0);
        @(posedge clk);
        #1;
        sample_valid = 1'b1;
        n_packed = '1;
        @(posedge clk);
        #1 sample_valid = 1'b0;
        wait_done(bc, seen);
        check("ovr_scan_done", 64'(seen), 64'd1);
        check("ovr_set", 64'(overrun), 64'd1);
        for (int g = 0; g < NUM_OSC; g++)
            check("ovr_dwell", 64'(dwell_packed[g*DWELL_W +: DWELL_W]), 64'd1);

        // Reset in the middle of a stalled event
        scan(np, bc);
        check("ovr_sticky", 64'(overrun), 64'd1);
        evt_ready = 1'b0;
        start_scan(np);
        wait_evt(seen);
        check("rstevt_evt_valid", 64'(seen), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rstevt_busy", 64'(busy), 64'd0);
        check("rstevt_evt_valid0", 64'(evt_valid), 64'd0);
        check("rstevt_overrun", 64'(overrun), 64'd0);
        check("rstevt_scan_done", 64'(scan_done), 64'd0);
        check("rstevt_evt_new", 64'(evt_new), 64'd0);
        check("rstevt_class0", 64'(class_packed[1:0]), 64'd0);
        check("rstevt_dwell1", 64'(dwell_packed[DWELL_W +: DWELL_W]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        evt_ready = 1'b1;
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (busy || scan_done || evt_valid) ok = 1'b0;
        end
        check("rstevt_idle_quiet", 64'(ok), 64'd1);
        check("final_evq_empty", 64'(evq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phi_position_tracker.md
Name: phi_position_tracker

Overview:
- Time-multiplexed, hysteresis-filtered successor to the per-oscillator φⁿ position classifier.
- Accepts a snapshot of NUM_OSC exponents (Q FRAC). Scans one channel per enabled cycle and classifies each channel as integer boundary, half-integer, quarter-integer or near-catastrophe.
- A class is committed only after CONFIRM consecutive agreeing scans. Per-channel dwell time is tracked, and committed class changes are emitted as handshaked events to the downstream energy-landscape controller.

Parameters:
- WIDTH, 18, exponent word width (signed).
- FRAC, 14, fractional bits of n.
- NUM_OSC, 21, channel count (≥2).
- CONFIRM, 3, consecutive identical raw classes needed to commit (1..15).
- DWELL_W, 8, dwell counter width (saturating).
- N_DANGER_LOW, 22118, inclusive lower bound of the 2:1 zone on full signed n.
- N_DANGER_HIGH, 25395, inclusive upper bound of the 2:1 zone.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- clk_en  in  1  advances FSM/scan only when high.
- sample_valid  in  1  start-of-scan request; n_packed is captured on the same cycle.
- n_packed  in  NUM_OSC*WIDTH  signed exponents, channel g at [g*WIDTH +: WIDTH].
- busy  out  1  high from capture through the last channel.
- scan_done  out  1  one-cycle pulse after the final channel is written.
- overrun  out  1  sticky; set when sample_valid is seen while busy; cleared only by rst.
- class_packed  out  NUM_OSC*2  committed class per channel: 00 INT, 01 HALF, 10 QUARTER, 11 CATASTROPHE.
- dwell_packed  out  NUM_OSC*DWELL_W  completed scans since the last commit change.
- stability_packed  out  NUM_OSC*WIDTH  signed Q FRAC stability (see Optional Feature).
- evt_valid  out  1  class-change event valid.
- evt_ready  in  1  consumer accepts the event.
- evt_chan  out  $clog2(NUM_OSC)  channel index of the event.
- evt_old  out  2  previous committed class.
- evt_new  out  2  new committed class.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE.
  - Per channel: committed class 00, candidate class 00, candidate count 0, dwell 0.
  - Snapshot register 0.
  - Reset mid-scan or mid-event aborts immediately; no scan_done is produced.
- FSM states IDLE, SCAN, EVT, DONE. All transitions require clk_en=1.
  - IDLE: on sample_valid, capture n_packed into the snapshot, set channel index to 0, go to SCAN. busy=1 from the next cycle.
  - SCAN: process channel idx (see below).
    - If a commit change occurs, load evt_* and go to EVT.
    - Otherwise, if idx=NUM_OSC-1 go to DONE, else idx+1.
  - EVT: hold evt_valid=1 and all evt_* stable until evt_valid && evt_ready.
    - A transfer may occur while clk_en=0.
    - The next state advance still waits for clk_en.
    - After the transfer, continue as SCAN would have: next idx, or DONE if idx was the last channel.
  - DONE: scan_done=1 for one cycle, busy=0, return to IDLE.
- sample_valid in any non-IDLE state: ignored, overrun set. sample_valid with clk_en=0: ignored, overrun not set.
- Raw class per channel:
  - frac = n[FRAC-1:0], unsigned; negative n uses the two's-complement floor.
  - q = (frac + 2^(FRAC-3)) >> (FRAC-2), range 0..4; ties round up.
  - q∈{0,4} → INT; q=2 → HALF; q∈{1,3} → QUARTER.
  - N_DANGER_LOW ≤ n ≤ N_DANGER_HIGH (signed) overrides to CATASTROPHE.
- Hysteresis:
  - If raw==candidate, count=min(count+1, CONFIRM); otherwise candidate=raw and count=1.
  - When count reaches CONFIRM and candidate ≠ committed: committed=candidate, dwell=0, event raised.
  - Otherwise dwell = dwell+1, saturating at 2^DWELL_W-1.
- Scan latency without events: NUM_OSC enabled cycles in SCAN plus 1 in DONE. Each event adds ≥1 cycle.
- class_packed and dwell_packed update at the channel's SCAN/EVT commit cycle. They are stable between scans.

Optional Feature:
- Macro: PPT_STABILITY_EN.
- Defined: stability_packed for a channel is written when it is scanned, from the raw class and distances d to the nearest reference point.
  - HALF: 2^FRAC - 4·|frac-2^(FRAC-1)|.
  - QUARTER: 2^(FRAC-1) - 2·d.
  - INT: 0.
  - CATASTROPHE: 2^(FRAC-2).
- Not defined: stability_packed is tied to 0 and no stability registers are built.

Test Plan:
- Reset then sample_valid with all n=0, clk_en=1 → busy for 21 cycles, then scan_done pulse; class 00, dwell 1 on all channels, no evt_valid.
- ch0 n=8192 (0.5), evt_ready=1, three scans → after 3rd scan ch0 class 01; one event chan=0, old=00, new=01; dwell ch0=0.
- ch3 n=23593 (1.44), three scans → class 11 and one event. Then n=36864 (2.25) for three scans → class 10, event old=11, new=10.
- ch1 alternating 8192/0 every scan for 10 scans → class stays 00, no events, dwell ch1=10.
- evt_ready=0 when ch0 commits → evt_valid held, busy=1, idx frozen for 50 cycles with fields stable. Raise evt_ready → scan completes, scan_done follows.
- sample_valid pulsed mid-scan → overrun=1 and scan unaffected. Assert rst mid-EVT → all outputs 0, FSM IDLE.
